// File: rtl/clk_divider_if.sv
// Divided-clock bundle: carries the clock_out of one clk_divider instance to its consumers.
interface clk_divider_if;
    logic clock_out;

    modport master (output clock_out);
    modport slave  (input  clock_out);
endinterface

// File: rtl/clk_divider_rst_sync.sv
// Reset synchronizer: asserts asynchronously, deasserts two clk rising edges after rst_n_in rises.
module rst_sync (
    input  logic clk,
    input  logic rst_n_in,
    output logic rst_n_out
);
    logic [1:0] sync_q, sync_d;

    // shift a constant 1 toward the output once reset is released
    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    // two-stage chain, cleared immediately by the raw reset
    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) sync_q <= 2'b00;
        else           sync_q <= sync_d;
    end

    assign rst_n_out = sync_q[1];
endmodule

// File: rtl/clk_divider.sv
// Integer clock divider with exact 50% duty for odd and even ratios.
// Even ratios use one rising-edge phase flop. Odd ratios OR that flop with a
// falling-edge copy, which stretches the high phase by half an input period.
// A ratio of 1 passes the input clock through, gated off while reset is low.
module clk_divider #(
    parameter int DIVISOR = 4
) (
    input  logic clock_in,
    input  logic rst_n,
    output logic clock_out
);
    if (DIVISOR < 1 || DIVISOR > 65535) begin : g_bad_divisor
        $error("clk_divider: DIVISOR must be in 1..65535");
    end

    if (DIVISOR == 1) begin : g_bypass
        assign clock_out = clock_in & rst_n;
    end else begin : g_div
        localparam int CNT_W = $clog2(DIVISOR);
        localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVISOR - 1);
        // Phase goes high at this count. For even ratios this is DIVISOR/2-1.
        // For odd ratios it is (DIVISOR-1)/2, leaving (DIVISOR-1)/2 rising-edge
        // cycles high before the falling copy adds the last half period.
        localparam logic [CNT_W-1:0] SET_CNT  = CNT_W'((DIVISOR - 1) / 2);

        logic             rst_n_sync;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             phase_q, phase_d;

        rst_sync u_rst_sync (
            .clk       (clock_in),
            .rst_n_in  (rst_n),
            .rst_n_out (rst_n_sync)
        );

        // next count (wrapping after DIVISOR-1) and next phase level
        always_comb begin
            cnt_d   = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
            phase_d = phase_q;
            if (cnt_q == SET_CNT)       phase_d = 1'b1;
            else if (cnt_q == LAST_CNT) phase_d = 1'b0;
        end

        // counter and rising-edge phase flop, held clear until synchronized release
        always_ff @(posedge clock_in or negedge rst_n_sync) begin
            if (!rst_n_sync) begin
                cnt_q   <= '0;
                phase_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                phase_q <= phase_d;
            end
        end

        if (DIVISOR % 2 == 0) begin : g_even
            assign clock_out = phase_q;
        end else begin : g_odd
            logic phase_f_q, phase_f_d;

            // the falling-edge copy simply follows the rising-edge phase
            always_comb begin
                phase_f_d = phase_q;
            end

            // half-period delayed copy that extends the high phase to DIVISOR/2 periods
            always_ff @(negedge clock_in or negedge rst_n_sync) begin
                if (!rst_n_sync) phase_f_q <= 1'b0;
                else             phase_f_q <= phase_f_d;
            end

            // both gate inputs are flop outputs, so the OR cannot glitch
            assign clock_out = phase_q | phase_f_q;
        end
    end
endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: DIVISOR 1..7 side by side, random reset pulses,
// outputs sampled mid half-period against a time-based waveform model.
module tb_clk_divider;
    localparam int NDUT = 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NDUT-1:0] outs;
    longint          t_rel = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    int              n_rise5 = 0;
    bit              cnt_en = 1'b0;

    always #10 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        clk_divider_if dif ();
        clk_divider #(.DIVISOR(g + 1)) u_dut (
            .clock_in  (clk),
            .rst_n     (rst_n),
            .clock_out (dif.clock_out)
        );
        assign outs[g] = dif.clock_out;
    end

    always @(posedge outs[4]) if (cnt_en) n_rise5++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Expected clock_out at time t. Input rising edges fall at 10+20n.
    // After rst_n rises, two edges pass through the synchronizer, the next edge
    // is the first counting edge, and the output first rises on counting edge
    // ceil(d/2). From then on the output is high for the first d*10 ns of every
    // d*20 ns period.
    function automatic bit model_out(int d, longint t);
        longint e1, tf;
        if (!rst_n) return 1'b0;
        if (d == 1) return (t % 20) >= 10;
        e1 = 10 + 20 * ((t_rel - 10) / 20 + 1);
        tf = e1 + 40 + 20 * ((d + 1) / 2 - 1);
        if (t < tf) return 1'b0;
        return ((t - tf) % (d * 20)) < (d * 10);
    endfunction

    // sample every 10 ns, midway between input clock edges
    initial begin
        #5;
        forever begin
            for (int i = 0; i < NDUT; i++)
                chk($sformatf("wave_d%0d", i + 1), int'(outs[i]),
                    int'(model_out(i + 1, longint'($time))));
            #10;
        end
    end

    // reset pulse starting at a time congruent to 3 mod 10; returns aligned the same way
    task automatic rst_pulse(input int low_ns);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++)
            chk($sformatf("rst_async_d%0d", i + 1), int'(outs[i]), 0);
        #(low_ns - 1);
        rst_n = 1'b1;
        t_rel = longint'($time);
    endtask

    initial begin
        int guard;
        #3;
        for (int i = 0; i < NDUT; i++)
            chk($sformatf("reset_d%0d", i + 1), int'(outs[i]), 0);
        #100;
        rst_n = 1'b1;
        t_rel = longint'($time);
        #(10 * 40);

        // short reset pulse in the middle of a DIVISOR=4 high phase
        guard = 0;
        while (!outs[3] && guard < 20) begin
            #10;
            guard++;
        end
        chk("wait_d4_high", int'(outs[3]), 1);
        rst_pulse(5);
        #5;
        #(10 * 30);

        // random reset pulses of random length, separated by random gaps
        repeat (12) begin
            #(10 * $urandom_range(5, 120));
            if ($urandom_range(0, 1) == 1) begin
                rst_pulse(5);
                #5;
            end else begin
                rst_pulse(10 * $urandom_range(1, 8));
            end
        end

        // free-running DIVISOR=5 for 1000 input cycles
        #(10 * 30);
        #2;
        n_rise5 = 0;
        cnt_en  = 1'b1;
        #20000;
        cnt_en  = 1'b0;
        chk("d5_rise_count", n_rise5, 200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
